spi_master_word: RTL and testbench

- Full-duplex SPI master that shifts one WIDTH-bit word out on MOSI_out while shifting one word in from MISO_in.
- Sits behind the CPU's SPI register file. The register file loads a word with a one-cycle valid strobe, polls the ready flags, and picks up the received word on the data_in_valid pulse.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, with spi_clk derived from clk.

---
 rtl/spi_master_word_if.sv | 32 +++
 rtl/spi_master_word.sv | 116 +++++++++++
 tb/tb_spi_master_word.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_word_if.sv
// CPU-side register-file bus of the word-wide SPI master: load strobe, ready flags
// and the received word with its completion pulse.
interface spi_master_word_if #(
   parameter int WIDTH = 32
);
   logic             transmit_ready_MOSI;
   logic             transmit_ready_MISO;
   logic [WIDTH-1:0] MOSI_data;
   logic             data_transmit_valid;
   logic [WIDTH-1:0] MISO_data;
   logic             data_in_valid;

   // Register-file side: issues words and collects results
   modport master (
      input  transmit_ready_MOSI,
      input  transmit_ready_MISO,
      input  MISO_data,
      input  data_in_valid,
      output MOSI_data,
      output data_transmit_valid
   );

   // SPI engine side
   modport slave (
      output transmit_ready_MOSI,
      output transmit_ready_MISO,
      output MISO_data,
      output data_in_valid,
      input  MOSI_data,
      input  data_transmit_valid
   );
endinterface

// File: rtl/spi_master_word.sv
// Full-duplex SPI master, mode 0, MSB first: shifts one WIDTH-bit word out on MOSI_out
// while capturing one word from MISO_in, with spi_clk divided down from clk.
module spi_master_word #(
   parameter int WIDTH   = 32,
   parameter int CLK_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   spi_master_word_if.slave bus,
   input  logic             MISO_in,
   output logic             spi_clk,
   output logic             MOSI_out
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state,    state_next;
   logic [WIDTH-1:0] tx_shift, tx_next;
   logic [WIDTH-1:0] rx_shift, rx_next;
   logic [WIDTH-1:0] rx_word,  rx_word_next;
   logic [DIV_W-1:0] div_cnt,  div_next;
   logic [BIT_W-1:0] bit_cnt,  bit_next;
   logic             sclk,     sclk_next;
   logic             mosi,     mosi_next;
   logic             done,     done_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_word  <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         tx_shift <= tx_next;
         rx_shift <= rx_next;
         rx_word  <= rx_word_next;
         div_cnt  <= div_next;
         bit_cnt  <= bit_next;
         sclk     <= sclk_next;
         mosi     <= mosi_next;
         done     <= done_next;
      end
   end

   // Each divider wrap is one spi_clk edge: rising samples MISO, falling advances MOSI,
   // and the falling edge after the last bit closes the transfer.
   always_comb begin
      state_next   = state;
      tx_next      = tx_shift;
      rx_next      = rx_shift;
      rx_word_next = rx_word;
      div_next     = div_cnt;
      bit_next     = bit_cnt;
      sclk_next    = sclk;
      mosi_next    = mosi;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.data_transmit_valid) begin
               state_next = SHIFT;
               tx_next    = bus.MOSI_data;
               mosi_next  = bus.MOSI_data[WIDTH-1];
               rx_next    = '0;
               div_next   = '0;
               bit_next   = '0;
               sclk_next  = 1'b0;
            end
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_next = '0;
               if (!sclk) begin
                  sclk_next = 1'b1;
                  rx_next   = {rx_shift[WIDTH-2:0], MISO_in};
               end else if (bit_cnt == BIT_LAST) begin
                  sclk_next    = 1'b0;
                  mosi_next    = 1'b0;
                  rx_word_next = rx_shift;
                  done_next    = 1'b1;
                  state_next   = IDLE;
               end else begin
                  sclk_next = 1'b0;
                  tx_next   = tx_shift << 1;
                  mosi_next = tx_shift[WIDTH-2];
                  bit_next  = bit_cnt + 1'b1;
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.transmit_ready_MOSI = (state == IDLE);
   assign bus.transmit_ready_MISO = (state == IDLE);
   assign bus.MISO_data           = rx_word;
   assign bus.data_in_valid       = done;
   assign spi_clk                 = sclk;
   assign MOSI_out                = mosi;

endmodule

// File: tb/tb_spi_master_word.sv
// Scoreboard bench for spi_master_word: a driver queues expected results, a monitor
// checks them on each data_in_valid against a simple SPI slave / loopback model.
module tb_spi_master_word;

   localparam int W   = 32;
   localparam int D   = 2;
   localparam int LAT = 2 * W * D;

   typedef struct {
      logic [W-1:0] rx;
      logic [W-1:0] tx;
      int           accept;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic MISO_in;
   logic spi_clk;
   logic MOSI_out;

   spi_master_word_if #(.WIDTH(W)) bus ();

   spi_master_word #(.WIDTH(W), .CLK_DIV(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .MISO_in (MISO_in),
      .spi_clk (spi_clk),
      .MOSI_out(MOSI_out)
   );

   always #5 clk = ~clk;

   exp_t         sb[$];
   exp_t         mon_e;
   int           errors = 0;
   int           checks = 0;
   int           cycle = 0;
   logic         mon_prev = 1'b0;
   logic         loopback = 1'b0;
   logic         slave_bit = 1'b0;
   logic [W-1:0] slave_shift = '0;
   logic [W-1:0] mosi_seen = '0;
   int           rise_count = 0;

   assign MISO_in = loopback ? MOSI_out : slave_bit;

   always @(posedge clk) cycle <= cycle + 1;

   // Slave model: records MOSI at every spi_clk rise and presents its word MSB first,
   // moving to the next bit on each spi_clk fall.
   initial forever begin
      @(posedge spi_clk);
      mosi_seen = {mosi_seen[W-2:0], MOSI_out};
      rise_count++;
   end

   initial forever begin
      @(negedge spi_clk);
      slave_shift = slave_shift << 1;
      slave_bit   = slave_shift[W-1];
   end

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // Monitor: pops the scoreboard on each completion pulse
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         checkOutput("ready_pair", W'(bus.transmit_ready_MISO), W'(bus.transmit_ready_MOSI));
         if (bus.transmit_ready_MOSI) checkOutput("idle_sclk", W'(spi_clk), W'(0));
         if (mon_prev) checkOutput("valid_one_cycle", W'(bus.data_in_valid), W'(0));
         if (bus.data_in_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: got pulse with MISO_data %h, expected no pulse", bus.MISO_data);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("rx_word", bus.MISO_data, mon_e.rx);
               checkOutput("latency", W'(cycle - mon_e.accept), W'(LAT));
               checkOutput("mosi_bits", mosi_seen, mon_e.tx);
               checkOutput("rise_count", W'(rise_count), W'(W));
               checkOutput("ready_after", W'(bus.transmit_ready_MOSI), W'(1));
            end
            rise_count = 0;
            mosi_seen  = '0;
         end
         mon_prev = bus.data_in_valid;
      end else begin
         mon_prev = 1'b0;
      end
   end

   task automatic waitReady();
      int n = 0;
      while (!bus.transmit_ready_MOSI && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_ready: got ready 0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic waitDone();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_done: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Issues one word at a negedge; expected receive word is the sent word in loopback,
   // otherwise the slave's word.
   task automatic applyStimulus(input logic [W-1:0] tx, input logic lb, input logic [W-1:0] sw);
      exp_t e;
      waitReady();
      loopback    = lb;
      slave_shift = sw;
      slave_bit   = sw[W-1];
      bus.MOSI_data           = tx;
      bus.data_transmit_valid = 1'b1;
      @(posedge clk);
      #1;
      e.rx     = lb ? tx : sw;
      e.tx     = tx;
      e.accept = cycle;
      sb.push_back(e);
      bus.data_transmit_valid = 1'b0;
      bus.MOSI_data           = $urandom;
      @(negedge clk);
      checkOutput("ready_drop", W'(bus.transmit_ready_MOSI), W'(0));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready_mosi"}, W'(bus.transmit_ready_MOSI), W'(1));
      checkOutput({tag, "_ready_miso"}, W'(bus.transmit_ready_MISO), W'(1));
      checkOutput({tag, "_spi_clk"}, W'(spi_clk), W'(0));
      checkOutput({tag, "_mosi_out"}, W'(MOSI_out), W'(0));
      checkOutput({tag, "_miso_data"}, bus.MISO_data, W'(0));
      checkOutput({tag, "_valid"}, W'(bus.data_in_valid), W'(0));
   endtask

   initial begin
      logic [W-1:0] tx;
      logic [W-1:0] sw;
      logic         lb;
      int           n;
      bus.data_transmit_valid = 1'b0;
      bus.MOSI_data           = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] loopback transfer");
      applyStimulus(32'hA5A50F0F, 1'b1, '0);
      waitDone();

      $display("[TB] constant MISO");
      applyStimulus(32'h00000000, 1'b0, 32'hFFFFFFFF);
      waitDone();
      applyStimulus(32'hFFFFFFFF, 1'b0, 32'h00000000);
      waitDone();

      $display("[TB] strobe while busy");
      applyStimulus(32'h12345678, 1'b1, '0);
      repeat (19) @(negedge clk);
      bus.MOSI_data           = 32'hDEADBEEF;
      bus.data_transmit_valid = 1'b1;
      @(negedge clk);
      checkOutput("busy_ready", W'(bus.transmit_ready_MOSI), W'(0));
      bus.data_transmit_valid = 1'b0;
      waitDone();
      repeat (5) @(negedge clk);
      checkOutput("not_queued", W'(bus.transmit_ready_MOSI), W'(1));
      checkOutput("busy_result", bus.MISO_data, 32'h12345678);

      $display("[TB] reset mid-transfer");
      applyStimulus(32'hFFFFFFFF, 1'b1, '0);
      repeat (49) @(negedge clk);
      #2 rst = 1'b1;
      #1 checkResetState("mid_reset");
      sb.delete();
      mosi_seen  = '0;
      rise_count = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 20) @(negedge clk);
      applyStimulus(32'h80000001, 1'b1, '0);
      waitDone();

      $display("[TB] back-to-back");
      sw = $urandom;
      applyStimulus($urandom, 1'b0, sw);
      n = 0;
      while (!bus.data_in_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2b_valid_seen", W'(bus.data_in_valid), W'(1));
      applyStimulus(32'h0F0F1234, 1'b1, '0);
      repeat (60) @(negedge clk);
      checkOutput("b2b_held", bus.MISO_data, sw);
      waitDone();

      $display("[TB] random transfers");
      for (int i = 0; i < 10; i++) begin
         lb = 1'($urandom_range(0, 1));
         tx = $urandom;
         sw = $urandom;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(tx, lb, sw);
      end
      waitDone();
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
